// File: rtl/systolic_pe_db.sv
// systolic_pe_db: weight-stationary signed MAC PE, double-buffered weight.
// Ports: act/valid W->E, psum N->S, weight shift chain N->S, swap, stall, ovf.
module systolic_pe_db #(
  parameter int DATA_W   = 16,
  parameter int ACC_W    = 32,
  parameter bit SATURATE = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              valid_west,
  input  logic [DATA_W-1:0] act_west,
  input  logic [ACC_W-1:0]  psum_north,
  output logic              valid_east,
  output logic [DATA_W-1:0] act_east,
  output logic [ACC_W-1:0]  psum_south,
  input  logic              wload_shift,
  input  logic [DATA_W-1:0] wload_in,
  output logic [DATA_W-1:0] wload_out,
  input  logic              weight_swap,
  output logic              ovf,
  input  logic              ovf_clr
);

  localparam int PW = 2 * DATA_W;

  logic [DATA_W-1:0] shadow;
  logic [DATA_W-1:0] active;

  logic [PW-1:0]    a_x;
  logic [PW-1:0]    w_x;
  logic [PW-1:0]    prod;
  logic [ACC_W:0]   prod_x;
  logic [ACC_W:0]   psum_x;
  logic [ACC_W:0]   sum;
  logic             ovf_now;
  logic [ACC_W-1:0] res;

  // Operands widened first so the low PW bits of the
  // product are the exact signed product.
  assign a_x    = {{DATA_W{act_west[DATA_W-1]}}, act_west};
  assign w_x    = {{DATA_W{active[DATA_W-1]}}, active};
  assign prod   = a_x * w_x;
  assign prod_x = {{(ACC_W + 1 - PW){prod[PW-1]}}, prod};
  assign psum_x = {psum_north[ACC_W-1], psum_north};
  assign sum    = psum_x + prod_x;

  // Top two bits disagree: result left the ACC_W range.
  assign ovf_now = sum[ACC_W] ^ sum[ACC_W-1];

  always_comb begin
    res = sum[ACC_W-1:0];
    if (SATURATE && ovf_now) begin
      if (sum[ACC_W])
        res = {1'b1, {(ACC_W-1){1'b0}}};
      else
        res = {1'b0, {(ACC_W-1){1'b1}}};
    end
  end

  assign wload_out = shadow;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_east <= 1'b0;
      act_east   <= '0;
      psum_south <= '0;
      shadow     <= '0;
      active     <= '0;
      ovf        <= 1'b0;
    end else begin
      if (wload_shift)
        shadow <= wload_in;
      if (weight_swap)
        active <= shadow;
      if (!stall) begin
        valid_east <= valid_west;
        if (valid_west) begin
          act_east   <= act_west;
          psum_south <= res;
        end
      end
      // Set has priority over clear.
      if (!stall && valid_west && ovf_now)
        ovf <= 1'b1;
      else if (ovf_clr)
        ovf <= 1'b0;
    end
  end

endmodule

// File: tb/tb_systolic_pe_db.sv
// tb_systolic_pe_db: directed checks of systolic_pe_db.
// Saturating and wrapping PEs share stimulus; a 3-PE chain checks loading.
module tb_systolic_pe_db;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall, vw, ws, swp, oc;
  logic [15:0] aw, wi;
  logic [31:0] pn;

  logic        ve, ov, ve2, ov2;
  logic [15:0] ae, wo, ae2, wo2;
  logic [31:0] ps, ps2;

  logic        c_shift;
  logic [15:0] c_in;
  logic [15:0] c_wi [3];
  logic [15:0] c_wo [3];
  logic        c_ve [3];
  logic [15:0] c_ae [3];
  logic [31:0] c_ps [3];
  logic        c_ov [3];

  int nvec = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  systolic_pe_db #(.DATA_W(16), .ACC_W(32), .SATURATE(1'b1)) dut (
    .clk(clk), .rst(rst), .stall(stall), .valid_west(vw),
    .act_west(aw), .psum_north(pn), .valid_east(ve),
    .act_east(ae), .psum_south(ps), .wload_shift(ws),
    .wload_in(wi), .wload_out(wo), .weight_swap(swp),
    .ovf(ov), .ovf_clr(oc)
  );

  systolic_pe_db #(.DATA_W(16), .ACC_W(32), .SATURATE(1'b0)) dut_w (
    .clk(clk), .rst(rst), .stall(stall), .valid_west(vw),
    .act_west(aw), .psum_north(pn), .valid_east(ve2),
    .act_east(ae2), .psum_south(ps2), .wload_shift(ws),
    .wload_in(wi), .wload_out(wo2), .weight_swap(swp),
    .ovf(ov2), .ovf_clr(oc)
  );

  assign c_wi[0] = c_in;
  assign c_wi[1] = c_wo[0];
  assign c_wi[2] = c_wo[1];

  for (genvar g = 0; g < 3; g++) begin : g_chain
    systolic_pe_db #(.DATA_W(16), .ACC_W(32), .SATURATE(1'b1)) pe (
      .clk(clk), .rst(rst), .stall(1'b0), .valid_west(1'b0),
      .act_west(16'h0), .psum_north(32'h0), .valid_east(c_ve[g]),
      .act_east(c_ae[g]), .psum_south(c_ps[g]),
      .wload_shift(c_shift), .wload_in(c_wi[g]),
      .wload_out(c_wo[g]), .weight_swap(1'b0),
      .ovf(c_ov[g]), .ovf_clr(1'b0)
    );
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    stall = 0; vw = 0; ws = 0; swp = 0; oc = 0;
    aw = '0; wi = '0; pn = '0;
  endtask

  task automatic load_weight(input logic [15:0] w);
    ws = 1; wi = w; swp = 0; vw = 0;
    step();
    ws = 0; swp = 1;
    step();
    swp = 0;
  endtask

  task automatic test_reset();
    idle();
    c_shift = 0; c_in = '0;
    rst = 0;
    #2;
    nvec++;
    if (ve !== 1'b0 || ps !== 32'h0 || ov !== 1'b0) begin
      nerr++;
      $display("FAIL reset_initial got ve=%b ps=%h ov=%b want 0",
               ve, ps, ov);
    end
    step();
    rst = 1;
    vw = 1; pn = 32'h1234; aw = 16'h0055;
    step();
    nvec++;
    if (ve !== 1'b1 || ps !== 32'h1234 || ae !== 16'h0055) begin
      nerr++;
      $display("FAIL reset_prefill got ve=%b ps=%h ae=%h want 1 1234 0055",
               ve, ps, ae);
    end
    ws = 1; wi = 16'h00AA;
    step();
    #2 rst = 0;
    #1;
    nvec++;
    if (ve !== 0 || ae !== 0 || ps !== 0 || wo !== 0 || ov !== 0) begin
      nerr++;
      $display("FAIL reset_async got ve=%b ae=%h ps=%h wo=%h ov=%b want 0",
               ve, ae, ps, wo, ov);
    end
    idle();
    step();
    step();
    nvec++;
    if (ve !== 0 || ps !== 0 || wo !== 0) begin
      nerr++;
      $display("FAIL reset_hold got ve=%b ps=%h wo=%h want 0",
               ve, ps, wo);
    end
    rst = 1;
  endtask

  task automatic test_mac();
    ws = 1; wi = 16'd7;
    step();
    nvec++;
    if (wo !== 16'd7) begin
      nerr++;
      $display("FAIL mac_shift got wo=%h want 0007", wo);
    end
    ws = 0; swp = 1;
    step();
    swp = 0;
    vw = 1; aw = 16'hFFFD; pn = 32'd100;
    step();
    nvec++;
    if (ps !== 32'd79 || ae !== 16'hFFFD || ve !== 1'b1) begin
      nerr++;
      $display("FAIL mac_signed got ps=%0d ae=%h ve=%b want 79 fffd 1",
               ps, ae, ve);
    end
    vw = 0; aw = 16'd5; pn = 32'd999;
    step();
    nvec++;
    if (ve !== 1'b0 || ps !== 32'd79 || ae !== 16'hFFFD || ov !== 0) begin
      nerr++;
      $display("FAIL mac_bubble got ve=%b ps=%0d ae=%h ov=%b want 0 79 fffd 0",
               ve, ps, ae, ov);
    end
  endtask

  task automatic test_saturation();
    load_weight(16'd8);
    vw = 1; aw = 16'd4; pn = 32'h7FFF_FFF0;
    step();
    nvec++;
    if (ps !== 32'h7FFF_FFFF || ov !== 1'b1) begin
      nerr++;
      $display("FAIL sat_pos got ps=%h ov=%b want 7fffffff 1", ps, ov);
    end
    nvec++;
    if (ps2 !== 32'h8000_0010 || ov2 !== 1'b1) begin
      nerr++;
      $display("FAIL wrap_pos got ps=%h ov=%b want 80000010 1", ps2, ov2);
    end
    vw = 0; oc = 1;
    step();
    oc = 0;
    nvec++;
    if (ov !== 1'b0 || ov2 !== 1'b0) begin
      nerr++;
      $display("FAIL ovf_clear got ov=%b ov2=%b want 0 0", ov, ov2);
    end
    load_weight(16'd4);
    vw = 1; aw = 16'hFFFC; pn = 32'h8000_0005;
    step();
    nvec++;
    if (ps !== 32'h8000_0000 || ov !== 1'b1) begin
      nerr++;
      $display("FAIL sat_neg got ps=%h ov=%b want 80000000 1", ps, ov);
    end
    nvec++;
    if (ps2 !== 32'h7FFF_FFF5 || ov2 !== 1'b1) begin
      nerr++;
      $display("FAIL wrap_neg got ps=%h ov=%b want 7ffffff5 1", ps2, ov2);
    end
    vw = 0;
  endtask

  task automatic test_double_buffer();
    load_weight(16'd2);
    vw = 1; aw = 16'd10; pn = 32'd1; ws = 1; wi = 16'd5;
    step();
    ws = 0;
    nvec++;
    if (ps !== 32'd21 || wo !== 16'd5) begin
      nerr++;
      $display("FAIL db_shift got ps=%0d wo=%0d want 21 5", ps, wo);
    end
    swp = 1; pn = 32'd3;
    step();
    swp = 0;
    nvec++;
    if (ps !== 32'd23) begin
      nerr++;
      $display("FAIL db_swap_edge got ps=%0d want 23", ps);
    end
    pn = 32'd0;
    step();
    nvec++;
    if (ps !== 32'd50) begin
      nerr++;
      $display("FAIL db_new_weight got ps=%0d want 50", ps);
    end
    vw = 0;
    c_shift = 1;
    for (int i = 1; i <= 3; i++) begin
      c_in = 16'(i);
      step();
    end
    c_shift = 0;
    nvec++;
    if (c_wo[2] !== 16'd1 || c_wo[1] !== 16'd2 || c_wo[0] !== 16'd3) begin
      nerr++;
      $display("FAIL chain got bot..top=%0d %0d %0d want 1 2 3",
               c_wo[2], c_wo[1], c_wo[0]);
    end
  endtask

  task automatic test_stall();
    oc = 1;
    step();
    oc = 0;
    load_weight(16'd5);
    vw = 1; aw = 16'd9; pn = 32'd0;
    step();
    nvec++;
    if (ps !== 32'd45 || ve !== 1'b1 || ov !== 1'b0) begin
      nerr++;
      $display("FAIL stall_pre got ps=%0d ve=%b ov=%b want 45 1 0",
               ps, ve, ov);
    end
    stall = 1; ws = 1; wi = 16'h0011;
    for (int i = 0; i < 3; i++) begin
      vw = (i % 2 == 0) ? 1'b0 : 1'b1;
      aw = 16'h7FFF;
      pn = 32'h7FFF_FFFF;
      step();
      ws = 0;
      nvec++;
      if (ve !== 1'b1 || ae !== 16'd9 || ps !== 32'd45 || ov !== 1'b0) begin
        nerr++;
        $display("FAIL stall_hold%0d got ve=%b ae=%h ps=%h ov=%b want 1 0009 2d 0",
                 i, ve, ae, ps, ov);
      end
    end
    nvec++;
    if (wo !== 16'h0011) begin
      nerr++;
      $display("FAIL stall_shift got wo=%h want 0011", wo);
    end
    stall = 0; vw = 0;
    step();
    nvec++;
    if (ve !== 1'b0 || ps !== 32'd45) begin
      nerr++;
      $display("FAIL stall_release got ve=%b ps=%0d want 0 45", ve, ps);
    end
  endtask

  task automatic test_ovf_clr();
    vw = 1; aw = 16'd1; pn = 32'h7FFF_FFFA;
    step();
    nvec++;
    if (ps !== 32'h7FFF_FFFF || ov !== 1'b0) begin
      nerr++;
      $display("FAIL edge_max got ps=%h ov=%b want 7fffffff 0", ps, ov);
    end
    aw = 16'h7FFF; pn = 32'h7FFF_FFFF; oc = 1;
    step();
    nvec++;
    if (ov !== 1'b1 || ps !== 32'h7FFF_FFFF) begin
      nerr++;
      $display("FAIL ovf_set_wins got ov=%b ps=%h want 1 7fffffff", ov, ps);
    end
    vw = 0;
    step();
    oc = 0;
    nvec++;
    if (ov !== 1'b0) begin
      nerr++;
      $display("FAIL ovf_clr_alone got ov=%b want 0", ov);
    end
  endtask

  initial begin
    test_reset();
    test_mac();
    test_saturation();
    test_double_buffer();
    test_stall();
    test_ovf_clr();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
